// File: rtl/jtopl_rhy_pkg.sv
// Shared constants and helpers for the OPL2 rhythm phase source.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jtopl_rhy_pkg;

   localparam int SLOTS    = 18;
   localparam int SLOT_HH  = 13;
   localparam int SLOT_TOM = 14;
   localparam int SLOT_SD  = 16;
   localparam int SLOT_TC  = 17;
   localparam int LFSR_W   = 23;
   localparam int LFSR_TAP = 14;

   // Ring-mod combination of the hi-hat and top-cymbal raw phases
   function automatic logic rm_xor_calc(input logic [9:0] hh_ph, input logic [9:0] tc_ph);
      return (hh_ph[2] ^ hh_ph[7]) | (hh_ph[3] ^ tc_ph[5]) | (tc_ph[3] ^ tc_ph[5]);
   endfunction

endpackage

// File: rtl/jtopl_noise.sv
// Purpose: 23-bit rhythm noise LFSR, advanced once per frame; optional hold/load under JTOPL_RHY_TEST_EN.
// Latency: new value visible the clk edge after a cen cycle with adv (or noise_ld) set.
// Backpressure: none; cen is the only throttle.
module jtopl_noise
   import jtopl_rhy_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 23'h1
)(
   input  logic              rst,
   input  logic              clk,
   input  logic              cen,
   input  logic              adv,
`ifdef JTOPL_RHY_TEST_EN
   input  logic              noise_hold,
   input  logic              noise_ld,
   input  logic [LFSR_W-1:0] noise_seed,
`endif
   output logic [LFSR_W-1:0] lfsr
);

   logic nb;
   logic step;

   assign nb = lfsr[0] ^ lfsr[LFSR_TAP];

`ifdef JTOPL_RHY_TEST_EN
   assign step = adv & ~noise_hold;
`else
   assign step = adv;
`endif

   // Shift right, feeding the tap XOR into the MSB; load wins over advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (cen) begin
`ifdef JTOPL_RHY_TEST_EN
         if (noise_ld)
            lfsr <= noise_seed;
         else if (step)
            lfsr <= {nb, lfsr[LFSR_W-1:1]};
`else
         if (step)
            lfsr <= {nb, lfsr[LFSR_W-1:1]};
`endif
      end
   end

endmodule

// File: rtl/jtopl_rhy_src.sv
// Purpose: OPL2 rhythm phase source: slot counter, HH/TC phase capture, rm_xor, noise, rhythm enables.
// Latency: captures and LFSR step visible one clk after their cen slot; enables/rm_xor combinational from regs.
// Backpressure: none; everything advances only on cen. Optional test port set: JTOPL_RHY_TEST_EN.
module jtopl_rhy_src
   import jtopl_rhy_pkg::*;
#(
   parameter int                SLOTS = 18,
   parameter logic [LFSR_W-1:0] SEED  = 23'h1
)(
   input  logic              rst,
   input  logic              clk,
   input  logic              cen,
   input  logic              zero,
   input  logic              rhy_en,
   input  logic [9:0]        phase_pre,
`ifdef JTOPL_RHY_TEST_EN
   input  logic              noise_hold,
   input  logic              noise_ld,
   input  logic [LFSR_W-1:0] noise_seed,
`endif
   output logic [4:0]        slot,
   output logic              hh_en,
   output logic              sd_en,
   output logic              tc_en,
   output logic [9:0]        hh,
   output logic              rm_xor,
   output logic              noise
);

   logic [9:0]        tc_q;
   logic [LFSR_W-1:0] lfsr;
   logic              is_hh;
   logic              is_sd;
   logic              is_tc;

   assign is_hh = (slot == 5'(SLOT_HH));
   assign is_sd = (slot == 5'(SLOT_SD));
   assign is_tc = (slot == 5'(SLOT_TC));

   // Slot counter: frame strobe forces 0 ahead of the natural wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         slot <= 5'd0;
      else if (cen) begin
         if (zero)
            slot <= 5'd0;
         else if (slot == 5'(SLOTS - 1))
            slot <= 5'd0;
         else
            slot <= slot + 5'd1;
      end
   end

   // Capture raw HH/TC phases once per frame, independent of rhythm mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hh   <= 10'd0;
         tc_q <= 10'd0;
      end else if (cen) begin
         if (is_hh) hh   <= phase_pre;
         if (is_tc) tc_q <= phase_pre;
      end
   end

   jtopl_noise #(.SEED(SEED)) u_noise (
      .rst        (rst),
      .clk        (clk),
      .cen        (cen),
      .adv        (is_tc),
`ifdef JTOPL_RHY_TEST_EN
      .noise_hold (noise_hold),
      .noise_ld   (noise_ld),
      .noise_seed (noise_seed),
`endif
      .lfsr       (lfsr)
   );

   assign hh_en  = rhy_en & is_hh;
   assign sd_en  = rhy_en & is_sd;
   assign tc_en  = rhy_en & is_tc;
   assign rm_xor = rm_xor_calc(hh, tc_q);
   assign noise  = lfsr[0];

endmodule

// File: tb/tb_jtopl_rhy_src.sv
// Directed bench for jtopl_rhy_src: sequencing, capture/rm_xor, LFSR frames, cen/zero, async reset.
// Inputs change and outputs are sampled 1 time unit after the rising clk edge.
// Test-port block is compiled when JTOPL_RHY_TEST_EN is defined.
module tb_jtopl_rhy_src;

   logic        rst, clk, cen, zero, rhy_en;
   logic [9:0]  phase_pre;
   logic [4:0]  slot;
   logic        hh_en, sd_en, tc_en, rm_xor, noise;
   logic [9:0]  hh;
`ifdef JTOPL_RHY_TEST_EN
   logic        noise_hold, noise_ld;
   logic [22:0] noise_seed;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [22:0] lfsr_m;
   logic [22:0] lfsr_snap;

   jtopl_rhy_src dut (
      .rst        (rst),
      .clk        (clk),
      .cen        (cen),
      .zero       (zero),
      .rhy_en     (rhy_en),
      .phase_pre  (phase_pre),
`ifdef JTOPL_RHY_TEST_EN
      .noise_hold (noise_hold),
      .noise_ld   (noise_ld),
      .noise_seed (noise_seed),
`endif
      .slot       (slot),
      .hh_en      (hh_en),
      .sd_en      (sd_en),
      .tc_en      (tc_en),
      .hh         (hh),
      .rm_xor     (rm_xor),
      .noise      (noise)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [22:0] lfsr_next(input logic [22:0] l);
      return {l[0] ^ l[14], l[22:1]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full frame from slot 0; optional per-slot enable checks and LFSR check at the end
   task automatic run_frame(input logic [9:0] ph13, input logic [9:0] ph17,
                            input logic en, input logic chk_en, input logic chk_lfsr);
      rhy_en = en;
      for (int s = 0; s < 18; s++) begin
         if (chk_en) begin
            chk("slot_seq", 32'(slot), 32'(s));
            chk("hh_en", 32'(hh_en), 32'(en && s == 13));
            chk("sd_en", 32'(sd_en), 32'(en && s == 16));
            chk("tc_en", 32'(tc_en), 32'(en && s == 17));
         end
         phase_pre = (s == 13) ? ph13 : (s == 17) ? ph17 : 10'h3FF;
         tick();
      end
      lfsr_m = lfsr_next(lfsr_m);
      if (chk_lfsr) begin
         chk("lfsr", 32'(dut.lfsr), 32'(lfsr_m));
         chk("noise", 32'(noise), 32'(lfsr_m[0]));
      end
   endtask

   initial begin
      rst = 1'b1; cen = 1'b1; zero = 1'b0; rhy_en = 1'b1; phase_pre = 10'd0;
`ifdef JTOPL_RHY_TEST_EN
      noise_hold = 1'b0; noise_ld = 1'b0; noise_seed = 23'd0;
`endif
      lfsr_m = 23'h1;
      #1;
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_noise", 32'(noise), 32'd1);
      chk("rst_hh", 32'(hh), 32'd0);
      chk("rst_rmx", 32'(rm_xor), 32'd0);
      tick(); tick();
      rst = 1'b0;
      // Frame start strobe holds slot at 0
      zero = 1'b1;
      tick();
      zero = 1'b0;
      chk("zero_start", 32'(slot), 32'd0);

      // Frame 1: hh=004, tc=000 -> rm_xor = hh[2]^hh[7] = 1; first LFSR step 1 -> 400000
      run_frame(10'h004, 10'h000, 1'b1, 1'b1, 1'b1);
      chk("lfsr_first", 32'(dut.lfsr), 32'h400000);
      chk("noise_first", 32'(noise), 32'd0);
      chk("wrap", 32'(slot), 32'd0);
      chk("hh_cap1", 32'(hh), 32'h004);
      chk("rmx1", 32'(rm_xor), 32'd1);
      // Frame 2, rhythm off: hh=008, tc=028 -> all three terms 0
      run_frame(10'h008, 10'h028, 1'b0, 1'b1, 1'b1);
      chk("hh_cap2", 32'(hh), 32'h008);
      chk("rmx2", 32'(rm_xor), 32'd0);
      // Frame 3: hh=000, tc=028 -> hh[3]^tc[5] = 1
      run_frame(10'h000, 10'h028, 1'b1, 1'b0, 1'b1);
      chk("rmx3", 32'(rm_xor), 32'd1);
      // Frames 4..64 against the LFSR model
      for (int f = 4; f <= 64; f++)
         run_frame(10'h000, 10'h000, 1'b1, 1'b0, 1'b1);
      chk("rmx_zero", 32'(rm_xor), 32'd0);

      // cen low for 5 cycles at slot 5: nothing moves
      for (int s = 0; s < 5; s++) tick();
      lfsr_snap = dut.lfsr;
      cen = 1'b0;
      phase_pre = 10'h3FF;
      for (int s = 0; s < 5; s++) tick();
      chk("cen_slot", 32'(slot), 32'd5);
      chk("cen_lfsr", 32'(dut.lfsr), 32'(lfsr_snap));
      chk("cen_hh", 32'(hh), 32'd0);
      cen = 1'b1;
      // zero at slot 7 restarts the frame without touching the LFSR
      tick(); tick();
      chk("pre_zero7", 32'(slot), 32'd7);
      zero = 1'b1;
      tick();
      zero = 1'b0;
      chk("zero7_slot", 32'(slot), 32'd0);
      chk("zero7_lfsr", 32'(dut.lfsr), 32'(lfsr_snap));
      // Run to slot 17, capture hh=004 on the way, then zero at slot 17
      for (int s = 0; s < 17; s++) begin
         phase_pre = (s == 13) ? 10'h004 : 10'h3FF;
         tick();
      end
      chk("pre_zero17", 32'(slot), 32'd17);
      zero = 1'b1;
      phase_pre = 10'h020;
      tick();
      zero = 1'b0;
      lfsr_m = lfsr_next(lfsr_m);
      chk("zero17_slot", 32'(slot), 32'd0);
      chk("zero17_lfsr", 32'(dut.lfsr), 32'(lfsr_m));
      chk("zero17_rmx", 32'(rm_xor), 32'd1);

      // Asynchronous reset mid-frame at slot 9
      for (int s = 0; s < 9; s++) tick();
      chk("pre_rst_slot", 32'(slot), 32'd9);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_slot", 32'(slot), 32'd0);
      chk("arst_noise", 32'(noise), 32'd1);
      chk("arst_hh", 32'(hh), 32'd0);
      chk("arst_rmx", 32'(rm_xor), 32'd0);
      chk("arst_en", 32'({hh_en, sd_en, tc_en}), 32'd0);
      tick();
      rst = 1'b0;

`ifdef JTOPL_RHY_TEST_EN
      noise_ld = 1'b1; noise_seed = 23'h7FFFFF;
      tick();
      noise_ld = 1'b0;
      chk("ld_lfsr", 32'(dut.lfsr), 32'h7FFFFF);
      noise_hold = 1'b1;
      for (int s = 0; s < 54; s++) tick();
      chk("hold_lfsr", 32'(dut.lfsr), 32'h7FFFFF);
      noise_hold = 1'b0;
      for (int s = 0; s < 18; s++) tick();
      chk("release_lfsr", 32'(dut.lfsr), 32'h3FFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
